spi_master_arb: RTL and testbench

- Arbitrated SPI master. Shares one SPI bus among NREQ byte-oriented requesters and sequences SS, SCK and MOSI for the team's SPI slave blocks.
- Slave-select is active-high, one bit per slave. Slave samples MOSI on SCK rise. Slave updates MISO after each SCK rise.
- Round-robin arbitration. A requester can lock the bus for a multi-byte burst: SS stays asserted between bytes.
- Each byte exchange returns the MISO byte to the granted requester.

---
 rtl/spi_master_arb_if.sv | 28 ++
 rtl/spi_master_arb.sv | 206 ++++++++++++++++++++
 tb/tb_spi_master_arb.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_arb_if.sv
// Requester-side bundle for spi_master_arb: byte offers in, responses out.
// master = requesters, slave = arbiter.
interface spi_master_arb_if #(
  parameter int NREQ = 2,
  parameter int NSS  = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*8-1:0]  req_data;
  logic [NREQ*SW-1:0] req_sel;
  logic [NREQ-1:0]    req_last;
  logic               rsp_valid;
  logic [IW-1:0]      rsp_id;
  logic [7:0]         rsp_data;

  modport master (
    output req_valid, req_data, req_sel, req_last,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, req_sel, req_last,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/spi_master_arb.sv
// Round-robin arbitrated SPI master (mode 0, MSB first) with burst lock.
// SPI_ARB_BURST_TIMEOUT_EN adds a burst-idle timeout and timeout_o flags.
module spi_master_arb #(
  parameter int NREQ     = 2,
  parameter int NSS      = 4,
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 4,
  parameter int SS_HOLD  = 2,
  parameter int GAP      = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic           Clk_i,
  input  logic           Rst_i,
  spi_master_arb_if.slave bus,
  output logic           busy_o,
  output logic           sck_o,
  output logic           mosi_o,
  output logic [NSS-1:0] ss_o,
  input  logic           miso_i
`ifdef SPI_ARB_BURST_TIMEOUT_EN
  ,
  output logic [NREQ-1:0] timeout_o
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = (NSS > 1) ? $clog2(NSS) : 1;
  localparam int HOLD_N = (SS_HOLD > 1) ? SS_HOLD - 1 : 1;
  localparam int M1 = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int M2 = (M1 > SS_SETUP + 1) ? M1 : SS_SETUP + 1;
  localparam int M3 = (M2 > TIMEOUT) ? M2 : TIMEOUT;
  localparam int M4 = (M3 > SS_HOLD) ? M3 : SS_HOLD;
  localparam int CW = $clog2(M4 + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_DONE,
    S_GAP, S_GAP_WAIT, S_HOLD, S_REL
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic            hi;
  logic [2:0]      bitn;
  logic [7:0]      tx, rx;
  logic [SW-1:0]   sel;
  logic            last;
  logic [IW-1:0]   id, rr;
  logic            lock;
  logic            gnt_ok;
  logic [IW-1:0]   gnt_idx;
  logic            acc;
  logic [IW-1:0]   acc_id;
  logic [NREQ-1:0] ready;
  logic            act;

  always_comb begin
    int j;
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(rr) + i) % NREQ;
      if (!gnt_ok && bus.req_valid[j]) begin
        gnt_ok  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  always_comb begin
    state_d = state;
    ready   = '0;
    acc     = 1'b0;
    acc_id  = (state == S_IDLE) ? gnt_idx : id;
    unique case (state)
      S_IDLE: begin
        if (!Rst_i && !lock && gnt_ok) begin
          ready[gnt_idx] = 1'b1;
          acc            = 1'b1;
          state_d        = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CW'(SS_SETUP)) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (hi && cnt == CW'(CLK_DIV - 1) && bitn == 3'd7)
          state_d = S_DONE;
      end
      S_DONE: begin
        state_d = last ? S_HOLD : S_GAP;
      end
      S_GAP: begin
        if (cnt == CW'(GAP - 1)) begin
          if (bus.req_valid[id]) begin
            ready[id] = 1'b1;
            acc       = 1'b1;
            state_d   = S_SHIFT;
          end else begin
            state_d = S_GAP_WAIT;
          end
        end
      end
      S_GAP_WAIT: begin
        if (bus.req_valid[id]) begin
          ready[id] = 1'b1;
          acc       = 1'b1;
          state_d   = S_SHIFT;
        end
`ifdef SPI_ARB_BURST_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT - 1)) begin
          state_d = S_HOLD;
        end
`endif
      end
      S_HOLD: begin
        if (cnt == CW'(HOLD_N - 1)) state_d = S_REL;
      end
      S_REL: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      hi    <= 1'b0;
      bitn  <= '0;
      tx    <= '0;
      rx    <= '0;
      sel   <= '0;
      last  <= 1'b0;
      id    <= '0;
      rr    <= '0;
      lock  <= 1'b0;
    end else begin
      state <= state_d;
      // rx samples at the end of the low phase, tx moves on the fall
      if (state == S_SHIFT) begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          cnt <= '0;
          hi  <= ~hi;
          if (!hi) begin
            rx <= {rx[6:0], miso_i};
          end else begin
            tx   <= {tx[6:0], 1'b0};
            bitn <= bitn + 3'd1;
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        hi   <= 1'b0;
        bitn <= '0;
        cnt  <= (state_d != state) ? '0 : cnt + 1'b1;
      end
      if (acc) begin
        tx   <= bus.req_data[8*int'(acc_id) +: 8];
        last <= bus.req_last[acc_id];
      end
      if (acc && state == S_IDLE) begin
        id  <= gnt_idx;
        sel <= bus.req_sel[SW*int'(gnt_idx) +: SW];
        rr  <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state == S_DONE && !last) lock <= 1'b1;
      if (state == S_HOLD && state_d == S_REL) lock <= 1'b0;
    end
  end

`ifdef SPI_ARB_BURST_TIMEOUT_EN
  logic [NREQ-1:0] to_q;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      to_q <= '0;
    end else begin
      if (acc && state == S_IDLE) to_q[gnt_idx] <= 1'b0;
      if (state == S_GAP_WAIT && state_d == S_HOLD)
        to_q[id] <= 1'b1;
    end
  end

  assign timeout_o = to_q;
`endif

  assign act = (state != S_IDLE) && (state != S_REL);

  always_comb begin
    ss_o = '0;
    for (int k = 0; k < NSS; k++) begin
      if (act && sel == SW'(k)) ss_o[k] = 1'b1;
    end
  end

  assign sck_o  = (state == S_SHIFT) && hi;
  assign mosi_o = (state == S_SETUP || state == S_SHIFT) && tx[7];
  assign busy_o = (state != S_IDLE);

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == S_DONE);
  assign bus.rsp_id    = id;
  assign bus.rsp_data  = rx;
endmodule

// File: tb/tb_spi_master_arb.sv
// Directed bench for spi_master_arb: echo/loopback SPI slave model,
// requester queues, grant/response monitors.
module tb_spi_master_arb;
  localparam int NREQ     = 2;
  localparam int NSS      = 2;
  localparam int CLK_DIV  = 4;
  localparam int SS_SETUP = 4;
  localparam int SS_HOLD  = 2;
  localparam int GAP      = 4;
  localparam int TIMEOUT  = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, sck, mosi, miso;
  logic [NSS-1:0] ss;
`ifdef SPI_ARB_BURST_TIMEOUT_EN
  logic [NREQ-1:0] timeout;
`endif

  always #5 clk = ~clk;

  spi_master_arb_if #(.NREQ(NREQ), .NSS(NSS)) bus ();

  spi_master_arb #(
    .NREQ(NREQ), .NSS(NSS), .CLK_DIV(CLK_DIV),
    .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD),
    .GAP(GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk_i(clk),
    .Rst_i(rst),
    .bus(bus),
    .busy_o(busy),
    .sck_o(sck),
    .mosi_o(mosi),
    .ss_o(ss),
    .miso_i(miso)
`ifdef SPI_ARB_BURST_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  typedef struct { logic [7:0] d; logic sel; logic last; } item_t;
  typedef struct { int id; int cyc; int falls; } gnt_t;
  typedef struct { int id; int d; int cyc; } rsp_t;

  item_t q0[$];
  item_t q1[$];
  gnt_t gq[$];
  rsp_t rq[$];
  logic [7:0] cq[$];

  int cyc = 0;
  int n_sckf = 0;
  int n_ssf = 0;
  int last_fall = 0;
  int ss_fall = 0;
  logic ovl = 1'b0;
  logic sck_p = 1'b0;
  logic [NSS-1:0] ss_p = '0;
  logic [NREQ-1:0] rdy_s = '0;
  int n_chk = 0;
  int n_fail = 0;

  logic loop = 1'b0;
  logic [7:0] slave_tx = 8'h3C;
  logic [7:0] sh = 8'h00;
  logic [7:0] cap = 8'h00;
  logic [2:0] nb = 3'd0;
  logic sck_d = 1'b0;
  logic ss_d = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave: loads its byte on SS rise, samples MOSI on SCK rise,
  // presents the next MISO bit right after the rise.
  always @(posedge clk) begin
    sck_d <= sck;
    ss_d  <= |ss;
    if (|ss && !ss_d) begin
      sh  <= slave_tx;
      nb  <= 3'd0;
      cap <= 8'h00;
    end else if (sck && !sck_d) begin
      cap <= {cap[6:0], mosi};
      if (nb == 3'd7) begin
        cq.push_back({cap[6:0], mosi});
        sh <= slave_tx;
        nb <= 3'd0;
      end else begin
        sh <= {sh[6:0], 1'b0};
        nb <= nb + 3'd1;
      end
    end
  end

  assign miso = loop ? mosi : sh[7];

  always @(negedge clk) begin
    if (|bus.req_ready)
      gq.push_back('{bus.req_ready[1] ? 1 : 0, cyc, n_ssf});
    if (bus.rsp_valid)
      rq.push_back('{int'(bus.rsp_id), int'(bus.rsp_data), cyc});
    if (sck_p && !sck) begin
      n_sckf    <= n_sckf + 1;
      last_fall <= cyc;
    end
    if (ss_p != '0 && ss == '0) begin
      n_ssf   <= n_ssf + 1;
      ss_fall <= cyc;
    end
    if ($countones(ss) > 1) ovl <= 1'b1;
    rdy_s <= bus.req_ready;
    sck_p <= sck;
    ss_p  <= ss;
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_sel   = '0;
    bus.req_last  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_s[0] && q0.size() > 0) void'(q0.pop_front());
      if (rdy_s[1] && q1.size() > 0) void'(q1.pop_front());
      bus.req_valid[0] = (q0.size() > 0);
      bus.req_valid[1] = (q1.size() > 0);
      if (q0.size() > 0) begin
        bus.req_data[7:0] = q0[0].d;
        bus.req_sel[0]    = q0[0].sel;
        bus.req_last[0]   = q0[0].last;
      end
      if (q1.size() > 0) begin
        bus.req_data[15:8] = q1[0].d;
        bus.req_sel[1]     = q1[0].sel;
        bus.req_last[1]    = q1[0].last;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_gq(input int n);
    int k = 0;
    while (gq.size() < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("grant_seen", 32'(gq.size() >= n), 1);
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (rq.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_seen", 32'(rq.size() >= n), 1);
  endtask

  task automatic wait_ssf(input int n);
    int k = 0;
    while (n_ssf < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("ss_fall_seen", 32'(n_ssf >= n), 1);
  endtask

  task automatic wait_sckf(input int n);
    int k = 0;
    while (n_sckf < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("sck_fall_seen", 32'(n_sckf >= n), 1);
  endtask

  initial begin
    int bg, br, bc, nf;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sck", sck, 0);
    chk("rst_mosi", mosi, 0);
    chk("rst_ss", ss, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_busy", busy, 0);

    // single byte to slave 1, echo slave returns 0x3C
    bg = gq.size(); br = rq.size(); bc = cq.size(); nf = n_ssf;
    q0.push_back('{8'hA5, 1'b1, 1'b1});
    wait_gq(bg + 1);
    repeat (3) @(negedge clk);
    chk("t1_ss_setup", ss, 2'b10);
    chk("t1_sck_setup", sck, 0);
    chk("t1_mosi_setup", mosi, 1);
    chk("t1_busy", busy, 1);
    wait_rsp(br + 1);
    chk("t1_gnt_id", gq[bg].id, 0);
    chk("t1_rsp_id", rq[br].id, 0);
    chk("t1_rsp_data", rq[br].d, 8'h3C);
    chk("t1_latency", rq[br].cyc - gq[bg].cyc, 70);
    chk("t1_mosi_byte", cq[bc], 8'hA5);
    wait_ssf(nf + 1);
    chk("t1_ss_hold", ss_fall - last_fall, SS_HOLD);
    repeat (4) @(negedge clk);

    // contention from reset: 0,1,0,1
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bg = gq.size(); br = rq.size();
    q0.push_back('{8'h01, 1'b0, 1'b1});
    q0.push_back('{8'h02, 1'b0, 1'b1});
    q1.push_back('{8'h81, 1'b1, 1'b1});
    q1.push_back('{8'h82, 1'b1, 1'b1});
    wait_rsp(br + 4);
    chk("t2_gnt0", gq[bg].id, 0);
    chk("t2_gnt1", gq[bg+1].id, 1);
    chk("t2_gnt2", gq[bg+2].id, 0);
    chk("t2_gnt3", gq[bg+3].id, 1);
    chk("t2_rsp_id3", rq[br+3].id, 1);
    chk("t2_regrant_gap", gq[bg+1].cyc - rq[br].cyc, 3);
    chk("t2_ss_overlap", ovl, 0);
    repeat (8) @(negedge clk);

    // burst on req1 while req0 waits
    bg = gq.size(); br = rq.size(); bc = cq.size();
    q1.push_back('{8'h11, 1'b1, 1'b0});
    q1.push_back('{8'h22, 1'b1, 1'b0});
    q1.push_back('{8'h33, 1'b1, 1'b1});
    wait_gq(bg + 1);
    q0.push_back('{8'h44, 1'b0, 1'b1});
    wait_rsp(br + 4);
    chk("t3_gnt0", gq[bg].id, 1);
    chk("t3_gnt1", gq[bg+1].id, 1);
    chk("t3_gnt2", gq[bg+2].id, 1);
    chk("t3_gnt3", gq[bg+3].id, 0);
    chk("t3_ss_falls", gq[bg+3].falls - gq[bg].falls, 1);
    chk("t3_req0_after", 32'(gq[bg+3].cyc > rq[br+2].cyc), 1);
    chk("t3_burst_lat", rq[br+1].cyc - gq[bg+1].cyc, 65);
    chk("t3_rsp_id2", rq[br+2].id, 1);
    chk("t3_mosi0", cq[bc], 8'h11);
    chk("t3_mosi1", cq[bc+1], 8'h22);
    chk("t3_mosi2", cq[bc+2], 8'h33);
    repeat (8) @(negedge clk);

    // loopback bit order
    loop = 1'b1;
    br = rq.size();
    q0.push_back('{8'hFF, 1'b0, 1'b1});
    q0.push_back('{8'h00, 1'b0, 1'b1});
    q0.push_back('{8'h1E, 1'b1, 1'b1});
    wait_rsp(br + 3);
    chk("t4_ff", rq[br].d, 8'hFF);
    chk("t4_00", rq[br+1].d, 8'h00);
    chk("t4_1e", rq[br+2].d, 8'h1E);
    repeat (8) @(negedge clk);

    // reset after bit 3 of a byte
    nf = n_sckf;
    q0.push_back('{8'hC3, 1'b0, 1'b1});
    wait_sckf(nf + 4);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_sck", sck, 0);
    chk("t5_ss", ss, 0);
    chk("t5_rsp_valid", bus.rsp_valid, 0);
    chk("t5_busy", busy, 0);
    rst = 1'b0;
    br = rq.size();
    repeat (100) @(negedge clk);
    chk("t5_no_rsp", rq.size(), br);
    bg = gq.size();
    q0.push_back('{8'h5A, 1'b1, 1'b1});
    wait_rsp(br + 1);
    chk("t5_data", rq[br].d, 8'h5A);
    chk("t5_id", rq[br].id, 0);
    chk("t5_latency", rq[br].cyc - gq[bg].cyc, 70);
    repeat (8) @(negedge clk);

`ifdef SPI_ARB_BURST_TIMEOUT_EN
    loop = 1'b0;
    br = rq.size(); nf = n_ssf;
    q0.push_back('{8'h77, 1'b0, 1'b0});
    wait_rsp(br + 1);
    q1.push_back('{8'h88, 1'b1, 1'b1});
    wait_ssf(nf + 1);
    chk("to_ss_drop", ss_fall - rq[br].cyc, GAP + TIMEOUT + SS_HOLD);
    chk("to_flag", timeout, 2'b01);
    wait_rsp(br + 2);
    chk("to_next_id", rq[br+1].id, 1);
    chk("to_flag_kept", timeout, 2'b01);
    q0.push_back('{8'h99, 1'b0, 1'b1});
    wait_rsp(br + 3);
    chk("to_clear", timeout, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
